// File: rtl/median_window_ctrl_if.sv
// Sample-in, FIFO-side and pair-out signal bundle for median_window_ctrl.
// slave = controller view, master = surrounding environment view.
interface median_window_ctrl_if #(
  parameter int unsigned DATA_W = 64
);
  logic              s_vld;
  logic [DATA_W-1:0] s_data;
  logic              s_rdy;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;
  logic              fifo_wr_vld;
  logic              fifo_rd_en;
  logic              fifo_rd_vld;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              m_vld;
  logic [DATA_W-1:0] m_new;
  logic [DATA_W-1:0] m_old;
  logic              m_warm;

  modport slave (
    input  s_vld, s_data, fifo_wr_vld, fifo_rd_vld, fifo_rd_data,
    output s_rdy, fifo_wr_en, fifo_wr_data, fifo_rd_en, m_vld, m_new, m_old, m_warm
  );

  modport master (
    output s_vld, s_data, fifo_wr_vld, fifo_rd_vld, fifo_rd_data,
    input  s_rdy, fifo_wr_en, fifo_wr_data, fifo_rd_en, m_vld, m_new, m_old, m_warm
  );
endinterface

// File: rtl/median_window_ctrl.sv
// Sliding-window sequencer over a FWFT FIFO: emits (newest, oldest) pairs per accepted sample.
// Optional accepted-sample counter enabled by MEDIAN_WINDOW_CTRL_STAT_EN.
module median_window_ctrl #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH_W   = 10,
  parameter int unsigned STALL_MAX = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               flush,
  input  logic [DEPTH_W-1:0] cfg_win_len,
  median_window_ctrl_if.slave bus,
  output logic [DEPTH_W-1:0] fill_cnt,
  output logic               busy,
  output logic               err_stall,
  output logic [31:0]        stat_cnt
);
  localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [DEPTH_W-1:0]  win_len_q, win_len_d;
  logic [DEPTH_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic                err_stall_q, err_stall_d;
  logic                busy_q, busy_d;
  logic                m_vld_q, m_vld_d;
  logic [DATA_W-1:0]   m_new_q, m_new_d;
  logic [DATA_W-1:0]   m_old_q, m_old_d;
  logic                m_warm_q, m_warm_d;
  logic                s_rdy_c;
  logic                rd_en_c;
  logic                accept;
  logic                start_go;

  // A sample coinciding with flush is refused so the drain count stays exact.
  always_comb begin
    s_rdy_c = 1'b0;
    unique case (state_q)
      FILL:    s_rdy_c = bus.fifo_wr_vld & ~flush;
      RUN:     s_rdy_c = bus.fifo_wr_vld & bus.fifo_rd_vld & ~flush;
      default: s_rdy_c = 1'b0;
    endcase
  end

  assign accept   = bus.s_vld & s_rdy_c;
  assign start_go = (state_q == IDLE) & start & ~flush;

  always_comb begin
    state_d     = state_q;
    win_len_d   = win_len_q;
    fill_cnt_d  = fill_cnt_q;
    stall_cnt_d = stall_cnt_q;
    err_stall_d = err_stall_q;
    m_vld_d     = 1'b0;
    m_new_d     = m_new_q;
    m_old_d     = m_old_q;
    m_warm_d    = m_warm_q;
    rd_en_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_go) begin
          win_len_d   = (cfg_win_len == '0) ? DEPTH_W'(1) : cfg_win_len;
          err_stall_d = 1'b0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (flush) begin
          state_d = FLUSH;
        end else if (accept) begin
          fill_cnt_d = fill_cnt_q + DEPTH_W'(1);
          m_vld_d    = 1'b1;
          m_new_d    = bus.s_data;
          m_old_d    = '0;
          m_warm_d   = 1'b0;
          if (fill_cnt_d == win_len_q) state_d = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = FLUSH;
        end else if (accept) begin
          rd_en_c  = 1'b1;
          m_vld_d  = 1'b1;
          m_new_d  = bus.s_data;
          m_old_d  = bus.fifo_rd_data;
          m_warm_d = 1'b1;
        end
      end
      FLUSH: begin
        rd_en_c = bus.fifo_rd_vld & (fill_cnt_q != '0);
        if (rd_en_c) fill_cnt_d = fill_cnt_q - DEPTH_W'(1);
        if (fill_cnt_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Stall watchdog only runs while the controller is willing to take samples.
    if (state_q == FILL || state_q == RUN) begin
      if (!bus.s_vld || accept) begin
        stall_cnt_d = '0;
      end else if (stall_cnt_q != STALL_W'(STALL_MAX)) begin
        stall_cnt_d = stall_cnt_q + STALL_W'(1);
      end
      if (stall_cnt_d == STALL_W'(STALL_MAX)) err_stall_d = 1'b1;
    end else begin
      stall_cnt_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_len_q   <= DEPTH_W'(1);
      fill_cnt_q  <= '0;
      stall_cnt_q <= '0;
      err_stall_q <= 1'b0;
      busy_q      <= 1'b0;
      m_vld_q     <= 1'b0;
      m_new_q     <= '0;
      m_old_q     <= '0;
      m_warm_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_len_q   <= win_len_d;
      fill_cnt_q  <= fill_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_stall_q <= err_stall_d;
      busy_q      <= busy_d;
      m_vld_q     <= m_vld_d;
      m_new_q     <= m_new_d;
      m_old_q     <= m_old_d;
      m_warm_q    <= m_warm_d;
    end
  end

`ifdef MEDIAN_WINDOW_CTRL_STAT_EN
  logic [31:0] stat_cnt_q, stat_cnt_d;

  always_comb begin
    stat_cnt_d = stat_cnt_q;
    if (start_go)    stat_cnt_d = '0;
    else if (accept) stat_cnt_d = stat_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_cnt_q <= '0;
    else     stat_cnt_q <= stat_cnt_d;
  end

  assign stat_cnt = stat_cnt_q;
`else
  assign stat_cnt = '0;
`endif

  assign bus.s_rdy        = s_rdy_c;
  assign bus.fifo_wr_en   = accept;
  assign bus.fifo_wr_data = bus.s_data;
  assign bus.fifo_rd_en   = rd_en_c;
  assign bus.m_vld        = m_vld_q;
  assign bus.m_new        = m_new_q;
  assign bus.m_old        = m_old_q;
  assign bus.m_warm       = m_warm_q;
  assign fill_cnt         = fill_cnt_q;
  assign busy             = busy_q;
  assign err_stall        = err_stall_q;
endmodule
